// File: rtl/dot_accum_if.sv
// Handshake bundle between the MAC stage, the dot-product accumulator and its consumer.
// The producer/consumer side uses master; the accumulator uses slave.
interface dot_accum_if #(
    parameter int IN_WIDTH  = 16,
    parameter int ACC_WIDTH = 32,
    parameter int LEN_WIDTH = 8
);
    logic        [LEN_WIDTH-1:0] len_i;
    logic                        in_valid;
    logic                        in_ready;
    logic signed [IN_WIDTH-1:0]  in_data;
    logic                        out_valid;
    logic                        out_ready;
    logic signed [ACC_WIDTH-1:0] out_data;
    logic                        out_sat;

    modport master (
        output len_i, in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_data, out_sat
    );

    modport slave (
        input  len_i, in_valid, in_data, out_ready,
        output in_ready, out_valid, out_data, out_sat
    );
endinterface

// File: rtl/dot_accum.sv
// Saturating accumulator that folds a programmable-length stream of MAC partial sums
// into one dot-product result, with a one-entry output register.
module dot_accum #(
    parameter int IN_WIDTH  = 16,
    parameter int ACC_WIDTH = 32,
    parameter int LEN_WIDTH = 8
) (
    input  logic       clk,
    input  logic       rst,
    dot_accum_if.slave bus
);

    typedef enum logic {IDLE = 1'b0, ACCUM = 1'b1} state_t;

    state_t                      state, state_nx;
    logic signed [ACC_WIDTH-1:0] acc, acc_nx;
    logic        [LEN_WIDTH-1:0] cnt, cnt_nx;
    logic        [LEN_WIDTH-1:0] len_q, len_nx;
    logic                        sat_q, sat_nx;
    logic                        out_valid_q, out_valid_nx;
    logic signed [ACC_WIDTH-1:0] out_data_q, out_data_nx;
    logic                        out_sat_q, out_sat_nx;

    logic                        accept;
    logic                        finish;
    logic                        ovf;
    logic        [LEN_WIDTH-1:0] eff_len;
    logic signed [ACC_WIDTH:0]   sum_w;
    logic signed [ACC_WIDTH-1:0] sum_c;

    // One guard bit above the accumulator is enough to detect any single-add overflow.
    function automatic logic signed [ACC_WIDTH:0] wide_add(
        input logic signed [ACC_WIDTH-1:0] a,
        input logic signed [IN_WIDTH-1:0]  b
    );
        logic signed [ACC_WIDTH:0] a_w;
        logic signed [ACC_WIDTH:0] b_w;
        a_w = {a[ACC_WIDTH-1], a};
        b_w = {{(ACC_WIDTH + 1 - IN_WIDTH){b[IN_WIDTH-1]}}, b};
        return a_w + b_w;
    endfunction

    function automatic logic sat_ovf(input logic signed [ACC_WIDTH:0] s);
        return s[ACC_WIDTH] != s[ACC_WIDTH-1];
    endfunction

    function automatic logic signed [ACC_WIDTH-1:0] sat_clamp(input logic signed [ACC_WIDTH:0] s);
        if (!sat_ovf(s))
            return s[ACC_WIDTH-1:0];
        else if (s[ACC_WIDTH])
            return {1'b1, {(ACC_WIDTH-1){1'b0}}};
        else
            return {1'b0, {(ACC_WIDTH-1){1'b1}}};
    endfunction

    // Ready depends only on the held result and the consumer, never on in_valid.
    assign bus.in_ready  = !out_valid_q || bus.out_ready;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = out_data_q;
    assign bus.out_sat   = out_sat_q;

    always_comb begin
        state_nx     = state;
        acc_nx       = acc;
        cnt_nx       = cnt;
        len_nx       = len_q;
        sat_nx       = sat_q;
        out_valid_nx = out_valid_q && !bus.out_ready;
        out_data_nx  = out_data_q;
        out_sat_nx   = out_sat_q;

        accept  = bus.in_valid && bus.in_ready;
        eff_len = (bus.len_i == '0) ? LEN_WIDTH'(1) : bus.len_i;
        // acc is always zero in IDLE, so the first beat is just a sign extension.
        sum_w   = wide_add(acc, bus.in_data);
        ovf     = sat_ovf(sum_w);
        sum_c   = sat_clamp(sum_w);
        finish  = accept && ((state == IDLE) ? (eff_len == LEN_WIDTH'(1))
                                             : (cnt + LEN_WIDTH'(1) == len_q));

        if (accept) begin
            if (state == IDLE)
                len_nx = eff_len;
            if (finish) begin
                state_nx     = IDLE;
                acc_nx       = '0;
                cnt_nx       = '0;
                sat_nx       = 1'b0;
                out_valid_nx = 1'b1;
                out_data_nx  = sum_c;
                out_sat_nx   = sat_q || ovf;
            end else begin
                state_nx = ACCUM;
                acc_nx   = sum_c;
                cnt_nx   = cnt + LEN_WIDTH'(1);
                sat_nx   = sat_q || ovf;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            acc         <= '0;
            cnt         <= '0;
            len_q       <= '0;
            sat_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
        end else begin
            state       <= state_nx;
            acc         <= acc_nx;
            cnt         <= cnt_nx;
            len_q       <= len_nx;
            sat_q       <= sat_nx;
            out_valid_q <= out_valid_nx;
            out_data_q  <= out_data_nx;
            out_sat_q   <= out_sat_nx;
        end
    end

endmodule
